// File: rtl/alu_issue_ctrl_if.sv
// Issue/result bundle between an instruction source, alu_issue_ctrl and its external ALU.
// The slave modport is the controller's view; the master modport is the environment's view.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [2:0]  alu_ctr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_illegal;
    logic        res_taken;

    modport slave (
        input  in_valid, instr, rs_data, rt_data, alu_out, alu_zero, res_ready,
        output in_ready, alu_ctr, alu_a, alu_b, res_valid, res_data, res_zero,
        output res_illegal, res_taken
    );

    modport master (
        output in_valid, instr, rs_data, rt_data, alu_out, alu_zero, res_ready,
        input  in_ready, alu_ctr, alu_a, alu_b, res_valid, res_data, res_zero,
        input  res_illegal, res_taken
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// MIPS ALU issue controller: decode, drive an external ALU for one cycle, hold the result.
// Define ALU_ISSUE_BRANCH_EN to decode beq/bne and report res_taken.
module alu_issue_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  opcode, funct;
    logic [15:0] imm;
    logic [31:0] imm_ext;
    logic        dec_illegal, dec_use_imm, dec_zext;
    logic [2:0]  dec_ctr;
    logic        accept;

    logic [2:0]  alu_ctr_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic        illegal_q;
    logic [31:0] res_data_q;
    logic        res_zero_q, res_illegal_q;

    // Register-number fields are not needed; operand values arrive on rs_data/rt_data.
    logic unused_instr;
    assign unused_instr = ^bus.instr[25:16];

    assign opcode  = bus.instr[31:26];
    assign funct   = bus.instr[5:0];
    assign imm     = bus.instr[15:0];
    assign imm_ext = dec_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign accept  = (state_q == StIdle) && bus.in_valid;

`ifdef ALU_ISSUE_BRANCH_EN
    logic dec_beq, dec_bne, beq_q, bne_q, res_taken_q;
`endif

    always_comb begin
        dec_illegal = 1'b0;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b0;
        dec_ctr     = 3'b000;
`ifdef ALU_ISSUE_BRANCH_EN
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
`endif
        case (opcode)
            6'b000000: begin
                dec_use_imm = 1'b0;
                case (funct)
                    6'b100000: dec_ctr = 3'b000;
                    6'b100001: dec_ctr = 3'b001;
                    6'b100101: dec_ctr = 3'b010;
                    6'b100010: dec_ctr = 3'b100;
                    6'b100011: dec_ctr = 3'b101;
                    6'b101010: dec_ctr = 3'b110;
                    6'b101011: dec_ctr = 3'b111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            6'b001000: dec_ctr = 3'b000;
            6'b001001: dec_ctr = 3'b001;
            6'b001101: begin
                dec_ctr  = 3'b011;
                dec_zext = 1'b1;
            end
            6'b001010: dec_ctr = 3'b110;
            6'b001011: dec_ctr = 3'b111;
`ifdef ALU_ISSUE_BRANCH_EN
            6'b000100: begin
                dec_ctr     = 3'b100;
                dec_use_imm = 1'b0;
                dec_beq     = 1'b1;
            end
            6'b000101: begin
                dec_ctr     = 3'b101;
                dec_use_imm = 1'b0;
                dec_bne     = 1'b1;
            end
`endif
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctr = 3'b000;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.in_valid) state_d = StExec;
            StExec:  state_d = StDone;
            StDone:  if (bus.res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            alu_ctr_q     <= 3'b000;
            alu_a_q       <= 32'h0;
            alu_b_q       <= 32'h0;
            illegal_q     <= 1'b0;
            res_data_q    <= 32'h0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_ctr_q <= dec_ctr;
                alu_a_q   <= bus.rs_data;
                alu_b_q   <= dec_use_imm ? imm_ext : bus.rt_data;
                illegal_q <= dec_illegal;
            end
            // Illegal instructions still run through EXEC but report a forced zero result.
            if (state_q == StExec) begin
                res_data_q    <= illegal_q ? 32'h0 : bus.alu_out;
                res_zero_q    <= illegal_q ? 1'b1 : bus.alu_zero;
                res_illegal_q <= illegal_q;
            end
        end
    end

`ifdef ALU_ISSUE_BRANCH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beq_q       <= 1'b0;
            bne_q       <= 1'b0;
            res_taken_q <= 1'b0;
        end else begin
            if (accept) begin
                beq_q <= dec_beq;
                bne_q <= dec_bne;
            end
            if (state_q == StExec) begin
                res_taken_q <= (beq_q & bus.alu_zero) | (bne_q & ~bus.alu_zero);
            end
        end
    end
    assign bus.res_taken = res_taken_q;
`else
    assign bus.res_taken = 1'b0;
`endif

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.res_valid   = (state_q == StDone);
    assign bus.alu_ctr     = alu_ctr_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.res_illegal = res_illegal_q;
endmodule
